// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice: fetch FSM states and
// the canonical no-op instruction shown to decode when no instruction is live.
package riscv_pkg;

  localparam int INST_W = 32;

  // addi x0,x0,0
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_gen.sv
// Program counter: word-aligned register with +4 increment and a redirect
// mux. A redirect overrides any increment requested in the same cycle.
module pc_gen #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_target;

  // Increment wraps modulo 2^ADDR_W; redirect targets have bits [1:0] cleared.
  assign w_pc_inc = r_pc + ADDR_W'(4);
  assign w_target = i_redirect_pc & ~ADDR_W'(3);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= w_target;
    end else if (i_inc) begin
      r_pc <= w_pc_inc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding req/gnt/valid transaction, a
// registered output slot toward decode, and a hold register for back-pressure.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              dec_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  fetch_state_e      r_state, w_state_nxt;
  logic              r_stale, w_stale_nxt;
  logic              r_inst_valid;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic [31:0]       r_hold;

  logic              w_slot_free;
  logic              w_load_slot;
  logic              w_from_hold;
  logic              w_capture_hold;
  logic              w_pc_inc;
  logic [ADDR_W-1:0] w_pc;

  pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_inc         (w_pc_inc),
    .i_redirect    (redirect_valid),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc)
  );

  // The slot can take a new word if it is empty or decode drains it this cycle.
  assign w_slot_free = !r_inst_valid || dec_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_stale_nxt    = r_stale;
    w_load_slot    = 1'b0;
    w_from_hold    = 1'b0;
    w_capture_hold = 1'b0;
    w_pc_inc       = 1'b0;
    unique case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        if (imem_gnt) begin
          w_state_nxt = WAIT;
          // A request granted under a redirect fetches the old path.
          if (redirect_valid) w_stale_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (imem_valid) begin
          w_state_nxt = FETCH;
          w_stale_nxt = 1'b0;
          if (!r_stale && !redirect_valid) begin
            if (w_slot_free) begin
              w_load_slot = 1'b1;
              w_pc_inc    = 1'b1;
            end else begin
              w_capture_hold = 1'b1;
              w_state_nxt    = HOLD;
            end
          end
        end else if (redirect_valid) begin
          w_stale_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_state_nxt = FETCH;
        end else if (w_slot_free) begin
          w_load_slot = 1'b1;
          w_from_hold = 1'b1;
          w_pc_inc    = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_stale <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stale <= w_stale_nxt;
    end
  end

  // Redirect flushes the slot even when decode is consuming it this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_valid <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= '0;
    end else if (redirect_valid) begin
      r_inst_valid <= 1'b0;
      r_inst       <= NOP_INST;
    end else if (w_load_slot) begin
      r_inst_valid <= 1'b1;
      r_inst       <= w_from_hold ? r_hold : imem_rdata;
      r_inst_pc    <= w_pc;
    end else if (r_inst_valid && dec_ready) begin
      r_inst_valid <= 1'b0;
      r_inst       <= NOP_INST;
    end
  end

  // NOTE: the hold register is pure data, only read while in HOLD after a
  // capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_capture_hold) r_hold <= imem_rdata;
  end

  assign imem_req   = (r_state == FETCH);
  assign imem_addr  = w_pc & ~ADDR_W'(3);
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

endmodule
